// File: rtl/lsu.sv
// Load/store unit: byte-addressed data memory plus memory-mapped LED/LCD output
// registers and a switch input, with one-cycle load latency and misalignment flagging.
module lsu #(
    parameter int DMEM_WORDS = 512
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    input  logic        i_lsu_rden,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_io_sw,
    output logic [31:0] o_ld_data,
    output logic        o_ld_valid,
    output logic        o_misalign,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [31:0] o_io_lcd
);

    localparam int AW = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);

    logic [31:0] dmem [DMEM_WORDS];

    logic          hit_dmem, hit_ledr, hit_ledg, hit_lcd, hit_sw;
    logic [AW-1:0] word_idx;
    logic          half_acc, word_acc, st_ok, ld_ok, addr_mis;
    logic          do_store, do_load;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   src_word, shifted, ld_result;
    logic [15:0]   half_v;
    logic          ld_valid_q, misalign_q;

    assign hit_dmem = i_lsu_addr < DMEM_BYTES;
    assign hit_ledr = i_lsu_addr[31:4] == 28'h1000000;
    assign hit_ledg = i_lsu_addr[31:4] == 28'h1000100;
    assign hit_lcd  = i_lsu_addr[31:4] == 28'h1000200;
    assign hit_sw   = i_lsu_addr[31:4] == 28'h1001000;
    assign word_idx = i_lsu_addr[AW+1:2];

    assign half_acc = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
    assign word_acc = (i_funct3 == 3'b010);
    assign st_ok    = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010);
    assign ld_ok    = st_ok || (i_funct3 == 3'b100) || (i_funct3 == 3'b101);
    assign addr_mis = (half_acc && i_lsu_addr[0]) || (word_acc && (i_lsu_addr[1:0] != 2'b00));

    // Store wins over a simultaneous load request.
    assign do_store = !i_reset && i_lsu_wren && st_ok && !addr_mis;
    assign do_load  = !i_reset && i_lsu_rden && !i_lsu_wren;

    always_comb begin
        be    = 4'b0000;
        wdata = i_st_data;
        case (i_funct3[1:0])
            2'b00: begin
                be[i_lsu_addr[1:0]] = 1'b1;
                wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{i_st_data[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] en);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = en[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

    always_comb begin
        src_word = 32'h0;
        if (hit_dmem)      src_word = dmem[word_idx];
        else if (hit_ledr) src_word = o_io_ledr;
        else if (hit_ledg) src_word = o_io_ledg;
        else if (hit_lcd)  src_word = o_io_lcd;
        else if (hit_sw)   src_word = i_io_sw;
    end

    assign shifted = src_word >> {i_lsu_addr[1:0], 3'b000};
    assign half_v  = i_lsu_addr[1] ? src_word[31:16] : src_word[15:0];

    always_comb begin
        ld_result = 32'h0;
        if (!addr_mis) begin
            case (i_funct3)
                3'b000:  ld_result = {{24{shifted[7]}}, shifted[7:0]};
                3'b001:  ld_result = {{16{half_v[15]}}, half_v};
                3'b010:  ld_result = src_word;
                3'b100:  ld_result = {24'h0, shifted[7:0]};
                3'b101:  ld_result = {16'h0, half_v};
                default: ld_result = 32'h0;
            endcase
        end
    end

    // Memory contents survive reset; only the write is blocked while reset is held.
    always_ff @(posedge i_clk) begin
        if (do_store && hit_dmem)
            dmem[word_idx] <= merge(dmem[word_idx], wdata, be);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_io_ledr  <= 32'h0;
            o_io_ledg  <= 32'h0;
            o_io_lcd   <= 32'h0;
            o_ld_data  <= 32'h0;
            ld_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            if (do_store && hit_ledr) o_io_ledr <= merge(o_io_ledr, wdata, be);
            if (do_store && hit_ledg) o_io_ledg <= merge(o_io_ledg, wdata, be);
            if (do_store && hit_lcd)  o_io_lcd  <= merge(o_io_lcd, wdata, be);
            if (do_load)              o_ld_data <= ld_result;
            ld_valid_q <= do_load;
            misalign_q <= (i_lsu_wren && st_ok && addr_mis) ||
                          (i_lsu_rden && !i_lsu_wren && ld_ok && addr_mis);
        end
    end

    // A reset arriving while a load result is being presented cancels the pulse.
    assign o_ld_valid = ld_valid_q && !i_reset;
    assign o_misalign = misalign_q && !i_reset;

endmodule
